cpu_sink: RTL

//  Consumer end of the cpu data_vld/data_rdy/data stream for CPU_NB cpu instances.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_sink_rr_arbiter.sv | 55 +++++
 rtl/cpu_sink.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu data stream: word type, sink FSM states and
// the LFSR used for ready throttling (also used by cpu-side benches).
package cpu_pkg;

    typedef logic [63:0] cpu_data_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        FAIL = 2'd2
    } sink_state_e;

    // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    // Right-shifting form: taps at bits 15, 13, 12, 10.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/cpu_sink_rr_arbiter.sv
// Round-robin arbiter. Owns the rotation pointer.
//   clk, rst_n  clock / async active-low reset
//   req_i       per-channel request
//   advance_i   the current grant was taken this cycle; move pointer past it
//   grant_o     one-hot (or zero) grant, first requester from the pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic          found;
    int            idx;

    // Search ptr, ptr+1, ... wrapping; first requester wins.
    always_comb begin
        grant_o = '0;
        win_idx = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win_idx      = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cpu_sink.sv
// Consumer end of the cpu data stream. Round-robin accepts at most one word
// per cycle, accumulates a 64-bit checksum, counts words per cpu and checks
// the producers' protocol and transaction counts.
//   clk, rst_n          clock / async active-low reset
//   data_vld, data      per-cpu word offer
//   transactions_done   per-cpu "all words sent" level
//   data_rdy            per-cpu ready, one-hot or zero
//   checksum            sum mod 2^64 of accepted words
//   total_count         accepted words, all channels (wraps at 2^32)
//   all_done            sticky: every cpu finished with the exact word count
//   error               sticky: a check failed
//   state_dbg           FSM state for observation
//
// Handshake: a word moves on a rising edge where data_vld[i] & data_rdy[i].
// Once a producer raises data_vld with data, both must hold until accepted.
module cpu_sink
    import cpu_pkg::*;
#(
    parameter int          CPU_NB         = 4,
    parameter int          TRANSACTION_NB = 10,
    parameter int          READY_MODE     = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CPU_NB-1:0]       data_vld,
    input  logic [CPU_NB-1:0][63:0] data,
    input  logic [CPU_NB-1:0]       transactions_done,
    output logic [CPU_NB-1:0]       data_rdy,
    output cpu_data_t               checksum,
    output logic [31:0]             total_count,
    output logic                    all_done,
    output logic                    error,
    output sink_state_e             state_dbg
);

    localparam int            CW       = $clog2(TRANSACTION_NB + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(TRANSACTION_NB);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TRANSACTION_NB + 1);

    sink_state_e              state_q, state_d;
    logic [15:0]              lfsr_q;
    cpu_data_t                checksum_q;
    logic [31:0]              total_q;
    logic [CW-1:0]            cnt_q [CPU_NB];
    logic [CW-1:0]            cnt_d [CPU_NB];
    logic                     all_done_q, all_done_d;
    logic                     error_q, error_d;
    logic [CPU_NB-1:0]        stall_q;
    logic [CPU_NB-1:0]        done_prev_q;
    logic [CPU_NB-1:0][63:0]  prev_data_q;

    logic [CPU_NB-1:0]        grant;
    logic [CPU_NB-1:0]        accept_vec;
    logic                     accept;
    logic                     ok;
    cpu_data_t                acc_word;
    logic                     overrun, proto_err, early_done, all_ok;

    rr_arbiter #(.N(CPU_NB)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (data_vld),
        .advance_i (accept),
        .grant_o   (grant)
    );

    assign ok         = (READY_MODE != 0) ? lfsr_q[0] : 1'b1;
    // rst_n gates ready combinationally so nothing is offered during reset.
    assign data_rdy   = grant & {CPU_NB{ok & (state_q != DONE) & rst_n}};
    assign accept_vec = data_vld & data_rdy;
    assign accept     = |accept_vec;

    always_comb begin
        acc_word = '0;
        for (int i = 0; i < CPU_NB; i++) begin
            if (accept_vec[i]) acc_word = data[i];
        end
    end

    // Per-cpu counting and protocol checks. A done edge is judged against
    // the count including a same-cycle accept.
    always_comb begin
        overrun    = 1'b0;
        proto_err  = 1'b0;
        early_done = 1'b0;
        all_ok     = 1'b1;
        for (int i = 0; i < CPU_NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept_vec[i]) begin
                if (cnt_q[i] >= CNT_FULL) overrun = 1'b1;
                if (cnt_q[i] != CNT_SAT) cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (stall_q[i] && (!data_vld[i] || (data[i] != prev_data_q[i]))) proto_err = 1'b1;
            if (transactions_done[i] && !done_prev_q[i] && (cnt_d[i] != CNT_FULL)) early_done = 1'b1;
            if (!transactions_done[i] || (cnt_q[i] != CNT_FULL)) all_ok = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        all_done_d = all_done_q;
        error_d    = error_q;
        case (state_q)
            RUN: begin
                if (overrun || proto_err || early_done) begin
                    state_d = FAIL;
                    error_d = 1'b1;
                end else if (all_ok) begin
                    state_d    = DONE;
                    all_done_d = 1'b1;
                end
            end
            DONE: begin
                if (|data_vld) begin
                    state_d = FAIL;
                    error_d = 1'b1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = FAIL;
                error_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            lfsr_q      <= LFSR_SEED;
            checksum_q  <= '0;
            total_q     <= '0;
            all_done_q  <= 1'b0;
            error_q     <= 1'b0;
            stall_q     <= '0;
            done_prev_q <= '0;
            prev_data_q <= '0;
            for (int i = 0; i < CPU_NB; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_next(lfsr_q);
            all_done_q  <= all_done_d;
            error_q     <= error_d;
            stall_q     <= data_vld & ~data_rdy;
            done_prev_q <= transactions_done;
            prev_data_q <= data;
            for (int i = 0; i < CPU_NB; i++) cnt_q[i] <= cnt_d[i];
            if (accept) begin
                checksum_q <= checksum_q + acc_word;
                total_q    <= total_q + 32'd1;
            end
        end
    end

    assign checksum    = checksum_q;
    assign total_count = total_q;
    assign all_done    = all_done_q;
    assign error       = error_q;
    assign state_dbg   = state_q;

endmodule
